// File: rtl/oqpsk_rcos_demod_if.sv
// Sample-in / bit-out bus of the OQPSK raised-cosine demodulator.
//   master : sample source and bit consumer (drives en, samples, bit_ready)
//   slave  : demodulator (drives bit stream, status and debug counters)
// Signals:
//   en           receiver enable
//   sample_valid i_sample/q_sample valid this cycle
//   i_sample     in-phase sample, signed DW_IN bits
//   q_sample     quadrature sample, signed DW_IN bits
//   bit_ready    consumer accepts bit_out
//   bit_valid    output FIFO non-empty
//   bit_out      recovered bit at FIFO head
//   low_conf     head bit came from a weak integrator result
//   overflow     sticky, a decision was dropped on a full FIFO
//   locked       receiver is tracking and emitting bits
//   cnt_i/cnt_q  per-rail symbol window counters (debug)
interface oqpsk_rcos_demod_if #(
    parameter int DW_IN = 13
);
    logic                    en;
    logic                    sample_valid;
    logic signed [DW_IN-1:0] i_sample;
    logic signed [DW_IN-1:0] q_sample;
    logic                    bit_ready;
    logic                    bit_valid;
    logic                    bit_out;
    logic                    low_conf;
    logic                    overflow;
    logic                    locked;
    logic [5:0]              cnt_i;
    logic [5:0]              cnt_q;

    modport master (
        output en, sample_valid, i_sample, q_sample, bit_ready,
        input  bit_valid, bit_out, low_conf, overflow, locked, cnt_i, cnt_q
    );

    modport slave (
        input  en, sample_valid, i_sample, q_sample, bit_ready,
        output bit_valid, bit_out, low_conf, overflow, locked, cnt_i, cnt_q
    );
endinterface

// File: rtl/oqpsk_rcos_demod.sv
// OQPSK raised-cosine receiver back end.
// Integrate-and-dump on each rail over PS_SMPLS samples, sign slicing, and a
// small first-word-fall-through FIFO that hands bits out in transmit order
// (I then Q). The Q window counter starts offset from I so the two rails
// never dump in the same cycle. The first SKIP_SYMS Q dumps after enable are
// thrown away while the pulse-overlap transient settles.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous reset, active high
//   bus  oqpsk_rcos_demod_if slave: samples in, bits/status out
module oqpsk_rcos_demod #(
    parameter int DW_IN     = 13,
    parameter int PS_SMPLS  = 50,
    parameter int INIT_I    = 0,
    parameter int INIT_Q    = 25,
    parameter int SKIP_SYMS = 3,
    parameter int CONF_TH   = 256,
    parameter int FIFO_D    = 4
) (
    input logic               clk,
    input logic               rst,
    oqpsk_rcos_demod_if.slave bus
);
    localparam int AW = DW_IN + $clog2(PS_SMPLS);
    localparam int SW = $clog2(SKIP_SYMS + 1);
    localparam int PW = $clog2(FIFO_D);

    localparam logic [5:0]           CNT_LAST = 6'(PS_SMPLS - 1);
    localparam logic signed [AW-1:0] TH       = AW'(CONF_TH);

    typedef enum logic [1:0] {IDLE, ACQUIRE, TRACK} state_t;

    state_t               state, state_nxt;
    logic signed [AW-1:0] acc_i, acc_q;
    logic signed [AW-1:0] s_i, s_q;
    logic [5:0]           cnt_i, cnt_q;
    logic [SW-1:0]        skip_cnt;

    logic accept, dump_i, dump_q;
    logic bit_i, bit_q, low_i, low_q;

    // FIFO entries are {bit, low}
    logic [1:0]    mem [FIFO_D];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic          wr_req, wr_ok, rd, full;
    logic [1:0]    wr_data;
    logic          overflow;

    // Datapath decode: dump sums include the sample arriving this cycle.
    always_comb begin
        accept = bus.en && bus.sample_valid && (state != IDLE);
        dump_i = accept && (cnt_i == CNT_LAST);
        dump_q = accept && (cnt_q == CNT_LAST);
        s_i    = acc_i + {{(AW-DW_IN){bus.i_sample[DW_IN-1]}}, bus.i_sample};
        s_q    = acc_q + {{(AW-DW_IN){bus.q_sample[DW_IN-1]}}, bus.q_sample};
        bit_i  = !s_i[AW-1];
        bit_q  = !s_q[AW-1];
        low_i  = (s_i < TH) && (s_i > -TH);
        low_q  = (s_q < TH) && (s_q > -TH);
    end

    always_comb begin
        state_nxt = state;
        if (!bus.en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = ACQUIRE;
                ACQUIRE: if (dump_q && skip_cnt == SW'(SKIP_SYMS - 1)) state_nxt = TRACK;
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            acc_i    <= '0;
            acc_q    <= '0;
            cnt_i    <= 6'(INIT_I);
            cnt_q    <= 6'(INIT_Q);
            skip_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (!bus.en) begin
                acc_i    <= '0;
                acc_q    <= '0;
                cnt_i    <= 6'(INIT_I);
                cnt_q    <= 6'(INIT_Q);
                skip_cnt <= '0;
            end else if (accept) begin
                acc_i <= dump_i ? '0 : s_i;
                acc_q <= dump_q ? '0 : s_q;
                cnt_i <= dump_i ? '0 : cnt_i + 6'd1;
                cnt_q <= dump_q ? '0 : cnt_q + 6'd1;
                if (state == ACQUIRE && dump_q) skip_cnt <= skip_cnt + SW'(1);
            end
        end
    end

    // Output FIFO. A pop on the same edge frees the slot for a write to a full FIFO.
    always_comb begin
        full    = (count == (PW+1)'(FIFO_D));
        rd      = (count != '0) && bus.bit_ready;
        wr_req  = (state == TRACK) && (dump_i || dump_q);
        wr_data = dump_i ? {bit_i, low_i} : {bit_q, low_q};
        wr_ok   = wr_req && (!full || rd);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_ok) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (rd) rd_ptr <= rd_ptr + PW'(1);
            count <= count + (PW+1)'(wr_ok) - (PW+1)'(rd);
            if (wr_req && !wr_ok) overflow <= 1'b1;
        end
    end

    // Head data is gated so the outputs read 0 while the FIFO is empty.
    assign bus.bit_valid = (count != '0);
    assign bus.bit_out   = bus.bit_valid && mem[rd_ptr][1];
    assign bus.low_conf  = bus.bit_valid && mem[rd_ptr][0];
    assign bus.overflow  = overflow;
    assign bus.locked    = (state == TRACK);
    assign bus.cnt_i     = cnt_i;
    assign bus.cnt_q     = cnt_q;
endmodule

// File: tb/tb_oqpsk_rcos_demod.sv
module tb_oqpsk_rcos_demod;
    localparam int PS = 50, INIT_I = 0, INIT_Q = 25, SKIP = 3, TH = 256, FD = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    oqpsk_rcos_demod_if #(.DW_IN(13)) bus();
    oqpsk_rcos_demod dut (.clk(clk), .rst(rst), .bus(bus));

    int n_vec = 0, n_err = 0;

    // Behavioural model: 0 idle, 1 acquiring, 2 tracking
    int       m_mode, m_ci, m_cq, m_ai, m_aq, m_skip;
    bit       m_ovf;
    bit [1:0] m_fifo[$];
    bit [1:0] dut_pops[$];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit [1:0] decide(input int s);
        return {s >= 0, (s < TH) && (s > -TH)};
    endfunction

    task automatic model_step(input bit r, e, v, input int iv, qv, input bit rdy);
        bit       pop, push, dq;
        bit [1:0] d;
        push = 0;
        dq   = 0;
        d    = 0;
        if (r) begin
            m_mode = 0; m_ci = INIT_I; m_cq = INIT_Q; m_ai = 0; m_aq = 0; m_skip = 0;
            m_ovf = 0;
            m_fifo.delete();
            return;
        end
        pop = (m_fifo.size() > 0) && rdy;
        if (!e) begin
            m_mode = 0; m_ci = INIT_I; m_cq = INIT_Q; m_ai = 0; m_aq = 0; m_skip = 0;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (v) begin
            m_ai += iv;
            m_aq += qv;
            if (m_ci == PS - 1) begin
                d = decide(m_ai); push = (m_mode == 2); m_ai = 0; m_ci = 0;
            end else m_ci++;
            if (m_cq == PS - 1) begin
                d = decide(m_aq); dq = 1; push = (m_mode == 2); m_aq = 0; m_cq = 0;
            end else m_cq++;
            if (m_mode == 1 && dq) begin
                m_skip++;
                if (m_skip == SKIP) m_mode = 2;
            end
        end
        if (push && m_fifo.size() == FD && !pop) m_ovf = 1;
        if (pop) void'(m_fifo.pop_front());
        if (push && !(m_ovf && m_fifo.size() == FD)) begin
            if (m_fifo.size() < FD) m_fifo.push_back(d);
        end
    endtask

    task automatic check_all();
        chk("bit_valid", bus.bit_valid, m_fifo.size() > 0);
        chk("bit_out", bus.bit_out, m_fifo.size() > 0 ? m_fifo[0][1] : 0);
        chk("low_conf", bus.low_conf, m_fifo.size() > 0 ? m_fifo[0][0] : 0);
        chk("overflow", bus.overflow, m_ovf);
        chk("locked", bus.locked, m_mode == 2);
        chk("cnt_i", bus.cnt_i, m_ci);
        chk("cnt_q", bus.cnt_q, m_cq);
    endtask

    // One clock: drive at the falling edge, step the model, check after the rising edge.
    task automatic cycle(input bit r, e, v, input int iv, qv, input bit rdy);
        if (bus.bit_valid && rdy) dut_pops.push_back({bus.bit_out, bus.low_conf});
        rst              = r;
        bus.en           = e;
        bus.sample_valid = v;
        bus.i_sample     = iv[12:0];
        bus.q_sample     = qv[12:0];
        bus.bit_ready    = rdy;
        model_step(r, e, v, iv, qv, rdy);
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    function automatic int rnd_smp();
        return int'($urandom_range(0, 8190)) - 4095;
    endfunction

    initial begin
        m_mode = 0; m_ci = INIT_I; m_cq = INIT_Q; m_ai = 0; m_aq = 0; m_skip = 0; m_ovf = 0;

        // Reset with enable asserted
        cycle(1, 1, 0, 0, 0, 0);
        cycle(1, 1, 0, 0, 0, 0);
        chk("rst_cnt_i", bus.cnt_i, 0);
        chk("rst_cnt_q", bus.cnt_q, 25);
        chk("rst_locked", bus.locked, 0);
        chk("rst_valid", bus.bit_valid, 0);

        // Constant +1000/-1000: alternating 1,0 high-confidence bits after lock
        dut_pops.delete();
        for (int k = 0; k < 400; k++) cycle(0, 1, 1, 1000, -1000, 1);
        chk("t2_locked", bus.locked, 1);
        chk("t2_npops", dut_pops.size() >= 4, 1);
        for (int k = 0; k < 4; k++) chk($sformatf("t2_pop%0d", k), dut_pops[k], (k % 2 == 0) ? 2 : 0);

        // Weak and zero integrals: bit 1, low confidence
        dut_pops.delete();
        for (int k = 0; k < 200; k++) cycle(0, 1, 1, 1, 0, 1);
        chk("t3_last", dut_pops[dut_pops.size()-1], 3);
        chk("t3_prev", dut_pops[dut_pops.size()-2], 3);

        // Back-pressure: five dumps into a 4-deep FIFO
        for (int k = 0; k < 60; k++) cycle(0, 1, 1, 1000, -1000, 1);
        for (int k = 0; k < 130; k++) cycle(0, 1, 1, 1000, -1000, 0);
        chk("t4_ovf", bus.overflow, 1);
        dut_pops.delete();
        for (int k = 0; k < 8; k++) cycle(0, 1, 0, 0, 0, 1);
        chk("t4_drained", dut_pops.size(), 4);
        chk("t4_alt", dut_pops[0][1] != dut_pops[1][1], 1);

        // Sparse samples: same sequence, 3x spacing
        cycle(1, 0, 0, 0, 0, 0);
        chk("t5_ovf_clr", bus.overflow, 0);
        dut_pops.delete();
        for (int k = 0; k < 1200; k++) cycle(0, 1, (k % 3) == 0, 1000, -1000, 1);
        chk("t5_npops", dut_pops.size() >= 4, 1);
        for (int k = 0; k < 4; k++) chk($sformatf("t5_pop%0d", k), dut_pops[k], (k % 2 == 0) ? 2 : 0);

        // Enable drop mid-window in TRACK keeps the FIFO
        for (int k = 0; k < 100 && bus.cnt_i != 20; k++) cycle(0, 1, 1, rnd_smp(), rnd_smp(), 0);
        chk("t6_at20", bus.cnt_i, 20);
        for (int k = 0; k < 3; k++) cycle(0, 0, 1, rnd_smp(), rnd_smp(), 0);
        chk("t6_cnt_i", bus.cnt_i, 0);
        chk("t6_cnt_q", bus.cnt_q, 25);
        chk("t6_unlocked", bus.locked, 0);
        for (int k = 0; k < 250; k++) cycle(0, 1, 1, rnd_smp(), rnd_smp(), 1);
        for (int k = 0; k < 100 && bus.cnt_i != 10; k++) cycle(0, 1, 1, rnd_smp(), rnd_smp(), 0);
        cycle(1, 1, 1, rnd_smp(), rnd_smp(), 0);
        chk("t6_rst_valid", bus.bit_valid, 0);
        chk("t6_rst_ovf", bus.overflow, 0);

        // Randomised traffic
        for (int k = 0; k < 4000; k++) begin
            bit r, e;
            r = ($urandom_range(0, 999) == 0);
            e = ($urandom_range(0, 299) != 0);
            cycle(r, e, $urandom_range(0, 3) != 0, rnd_smp(), rnd_smp(), $urandom_range(0, 1) == 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
